// File: rtl/program_encoder_if.sv
// Request and program-memory write buses of the program encoder.
// master = encoder side, slave = host/loader plus memory side.
interface program_encoder_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic [5:0]    req_opcode;
  logic [1:0]    req_pred;
  logic [7:0]    req_rd;
  logic [7:0]    req_rs;
  logic [7:0]    req_rt_imm;
  logic          req_last;
  logic          mem_write_valid;
  logic          mem_write_ready;
  logic [AW-1:0] mem_write_address;
  logic [DW-1:0] mem_write_data;

  modport master (
    input  req_valid, req_opcode, req_pred,
    input  req_rd, req_rs, req_rt_imm, req_last,
    output req_ready,
    output mem_write_valid, mem_write_address,
    output mem_write_data,
    input  mem_write_ready
  );

  modport slave (
    output req_valid, req_opcode, req_pred,
    output req_rd, req_rs, req_rt_imm, req_last,
    input  req_ready,
    input  mem_write_valid, mem_write_address,
    input  mem_write_data,
    output mem_write_ready
  );
endinterface

// File: rtl/program_encoder.sv
// Encodes instruction requests into 32-bit words and streams them
// into program memory at consecutive addresses, optionally closing with RET.
module program_encoder #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 32,
  parameter bit AUTO_RET              = 1'b1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] base_addr,
  program_encoder_if.master                bus,
  output logic                             busy,
  output logic                             done,
  output logic                             error,
  output logic [1:0]                       error_code,
  output logic [PROGRAM_MEM_ADDR_BITS:0]   instr_count
);
  localparam int AW = PROGRAM_MEM_ADDR_BITS;
  localparam int DW = PROGRAM_MEM_DATA_BITS;

  localparam logic [5:0]    OP_RET   = 6'b111111;
  localparam logic [DW-1:0] RET_WORD = {OP_RET, {(DW-6){1'b0}}};
  localparam logic [AW+1:0] NEED1    = {{(AW+1){1'b0}}, 1'b1};
  localparam logic [AW+1:0] NEED2    = {{AW{1'b0}}, 2'b10};
  localparam logic [AW+1:0] WORDS    = {2'b01, {AW{1'b0}}};
  localparam logic [AW:0]   INC      = {{AW{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_RET,
    S_DONE,
    S_ERROR
  } state_e;

  state_e        state_q, state_d;
  logic [AW:0]   ptr_q, ptr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          last_q, last_d;
  logic          ret_q, ret_d;
  logic [1:0]    code_q, code_d;
  logic [AW:0]   cnt_q, cnt_d;

  logic          wr_en;
  logic          wr_fire;
  logic          ret_need;
  logic          op_legal;
  logic [AW+1:0] end_ptr;

  function automatic logic legal(input logic [5:0] op);
    case (op)
      6'b000000, 6'b000001, 6'b000010,
      6'b010000, 6'b010001, 6'b010010,
      6'b100000, 6'b100001, 6'b100010,
      6'b110000, 6'b110001, 6'b110010,
      6'b000100, 6'b010100, 6'b000101,
      6'b010101, 6'b000111, 6'b010111,
      6'b000110, 6'b010110, 6'b101100,
      6'b111100, 6'b001101, 6'b111111:
        legal = 1'b1;
      default:
        legal = 1'b0;
    endcase
  endfunction

  assign wr_en    = (state_q == S_WRITE) ||
                    (state_q == S_RET);
  assign wr_fire  = wr_en & bus.mem_write_ready;
  assign op_legal = legal(bus.req_opcode);
  assign ret_need = AUTO_RET && bus.req_last &&
                    (bus.req_opcode != OP_RET);
  // room for the word itself plus the trailing RET it implies
  assign end_ptr  = {1'b0, ptr_q} + (ret_need ? NEED2 : NEED1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    last_d  = last_q;
    ret_d   = ret_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          ptr_d   = {1'b0, base_addr};
          cnt_d   = '0;
          code_d  = 2'b00;
          state_d = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        if (bus.req_valid) begin
          if (!op_legal) begin
            code_d  = 2'b01;
            state_d = S_ERROR;
          end else if (end_ptr > WORDS) begin
            code_d  = 2'b10;
            state_d = S_ERROR;
          end else begin
            data_d  = {bus.req_opcode, bus.req_pred,
                       bus.req_rd, bus.req_rs,
                       bus.req_rt_imm};
            addr_d  = ptr_q[AW-1:0];
            last_d  = bus.req_last;
            ret_d   = ret_need;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (wr_fire) begin
          ptr_d = ptr_q + INC;
          cnt_d = cnt_q + INC;
          if (!last_q) begin
            state_d = S_ACCEPT;
          end else if (ret_q) begin
            data_d  = RET_WORD;
            addr_d  = ptr_d[AW-1:0];
            state_d = S_RET;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RET: begin
        if (wr_fire) begin
          ptr_d   = ptr_q + INC;
          cnt_d   = cnt_q + INC;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      ret_q   <= 1'b0;
      code_q  <= 2'b00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      last_q  <= last_d;
      ret_q   <= ret_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.req_ready         = (state_q == S_ACCEPT);
  assign bus.mem_write_valid   = wr_en;
  assign bus.mem_write_address = addr_q;
  assign bus.mem_write_data    = data_q;

  assign busy        = (state_q == S_ACCEPT) || wr_en;
  assign done        = (state_q == S_DONE);
  assign error       = (state_q == S_ERROR);
  assign error_code  = code_q;
  assign instr_count = cnt_q;
endmodule
